seq_alu: RTL and testbench

Multi-cycle integer execute unit for the RV32I datapath, sitting directly downstream of the ALU control decoder and consuming its 4-bit `ALUops` code together with the two 32-bit operands. It produces a registered 32-bit result and a branch-taken flag, signalled with a single-cycle `DONE` pulse. Non-shift operations complete in one cycle. Shifts use an area-saving serial shifter unless the fast-shift build option is compiled in.

---
 rtl/seq_alu.sv | 168 ++++++++++++++++
 tb/tb_seq_alu.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Multi-cycle RV32I execute unit: ALU ops, compares/branches, serial or barrel shifts (option SEQ_ALU_FAST_SHIFT_EN).
// Latency: 1 cycle for non-shift ops; shifts take amount+1 cycles (1 cycle when SEQ_ALU_FAST_SHIFT_EN is defined).
// Backpressure: START is taken only while BUSY=0; a START during a serial shift is dropped, not queued.
module seq_alu #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [3:0]      ALUops,
    input  logic            UNSIGNED,
    input  logic [XLEN-1:0] OPA,
    input  logic [XLEN-1:0] OPB,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT,
    output logic            BRANCH
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SRL  = 4'd3;
    localparam logic [3:0] OP_SRA  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_EQ   = 4'd9;
    localparam logic [3:0] OP_NE   = 4'd10;
    localparam logic [3:0] OP_LT   = 4'd11;
    localparam logic [3:0] OP_GE   = 4'd12;
    localparam logic [3:0] OP_PASS = 4'd15;

`ifdef SEQ_ALU_FAST_SHIFT_EN
    typedef enum logic [1:0] {IDLE, FINISH} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
`endif

    state_t          state;
    logic [XLEN-1:0] imm_res;
    logic            imm_br;
    logic            lt;
    logic            is_shift;

    // Single-cycle result straight from the accepted inputs (registered on the accept edge).
    always_comb begin
        imm_res  = '0;
        imm_br   = 1'b0;
        lt       = UNSIGNED ? (OPA < OPB) : ($signed(OPA) < $signed(OPB));
        is_shift = (ALUops == OP_SLL) || (ALUops == OP_SRL) || (ALUops == OP_SRA);
        case (ALUops)
            OP_ADD:  imm_res = OPA + OPB;
            OP_SUB:  imm_res = OPA - OPB;
`ifdef SEQ_ALU_FAST_SHIFT_EN
            OP_SLL:  imm_res = OPA << OPB[4:0];
            OP_SRL:  imm_res = OPA >> OPB[4:0];
            OP_SRA:  imm_res = $unsigned($signed(OPA) >>> OPB[4:0]);
`else
            // Only reached with a zero shift amount; the operand passes through.
            OP_SLL, OP_SRL, OP_SRA: imm_res = OPA;
`endif
            OP_XOR:  imm_res = OPA ^ OPB;
            OP_OR:   imm_res = OPA | OPB;
            OP_AND:  imm_res = OPA & OPB;
            OP_SLT:  imm_res = {{(XLEN-1){1'b0}}, lt};
            OP_EQ:   imm_br  = (OPA == OPB);
            OP_NE:   imm_br  = (OPA != OPB);
            OP_LT:   imm_br  = lt;
            OP_GE:   imm_br  = ~lt;
            OP_PASS: imm_res = OPB;
            default: begin
                imm_res = '0;
                imm_br  = 1'b0;
            end
        endcase
    end

`ifdef SEQ_ALU_FAST_SHIFT_EN
    assign BUSY = 1'b0;

    // Every op completes on the accept edge; FINISH only exists to pulse DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            DONE   <= 1'b0;
            RESULT <= '0;
            BRANCH <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (START) begin
                RESULT <= imm_res;
                BRANCH <= imm_br;
                DONE   <= 1'b1;
                state  <= FINISH;
            end else begin
                state  <= IDLE;
            end
        end
    end
`else
    logic [3:0]      op_q;
    logic [4:0]      cnt_q;
    logic [XLEN-1:0] sh_q;
    logic [XLEN-1:0] sh_nxt;
    logic            busy_q;

    assign BUSY = busy_q;

    // One-bit step of the serial shifter for the latched shift kind.
    always_comb begin
        case (op_q)
            OP_SLL:  sh_nxt = {sh_q[XLEN-2:0], 1'b0};
            OP_SRL:  sh_nxt = {1'b0, sh_q[XLEN-1:1]};
            default: sh_nxt = {sh_q[XLEN-1], sh_q[XLEN-1:1]};
        endcase
    end

    // Control FSM with registered outputs; reset abandons any shift in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            DONE   <= 1'b0;
            RESULT <= '0;
            BRANCH <= 1'b0;
            op_q   <= '0;
            cnt_q  <= '0;
            sh_q   <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                SHIFT: begin
                    sh_q  <= sh_nxt;
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        RESULT <= sh_nxt;
                        BRANCH <= 1'b0;
                        DONE   <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= FINISH;
                    end
                end
                default: begin
                    if (START) begin
                        if (is_shift && (OPB[4:0] != 5'd0)) begin
                            op_q   <= ALUops;
                            sh_q   <= OPA;
                            cnt_q  <= OPB[4:0];
                            busy_q <= 1'b1;
                            state  <= SHIFT;
                        end else begin
                            RESULT <= imm_res;
                            BRANCH <= imm_br;
                            DONE   <= 1'b1;
                            state  <= FINISH;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [3:0]  ALUops;
    logic        UNSIGNED;
    logic [31:0] OPA;
    logic [31:0] OPB;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;
    logic        BRANCH;

    int n_cmp = 0;
    int n_err = 0;

    // Last completed result as the model sees it; outputs must hold it between completions.
    logic [31:0] hold_res = 32'h0;
    logic        hold_br  = 1'b0;

`ifdef SEQ_ALU_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    seq_alu #(.XLEN(32)) dut (
        .CLK(CLK), .RST(RST), .START(START), .ALUops(ALUops), .UNSIGNED(UNSIGNED),
        .OPA(OPA), .OPB(OPB), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .BRANCH(BRANCH)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour written from the instruction semantics.
    function automatic void model(input logic [3:0] op, input logic uns, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r, output logic br);
        logic lt;
        lt = uns ? (a < b) : ($signed(a) < $signed(b));
        r  = 32'h0;
        br = 1'b0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a << b[4:0];
            4'd3:  r = a >> b[4:0];
            4'd4:  r = $unsigned($signed(a) >>> b[4:0]);
            4'd5:  r = a ^ b;
            4'd6:  r = a | b;
            4'd7:  r = a & b;
            4'd8:  r = {31'h0, lt};
            4'd9:  br = (a == b);
            4'd10: br = (a != b);
            4'd11: br = lt;
            4'd12: br = !lt;
            4'd15: r = b;
            default: ;
        endcase
    endfunction

    function automatic bit serial_shift(input logic [3:0] op);
        return !FAST && (op == 4'd2 || op == 4'd3 || op == 4'd4);
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
        return serial_shift(op) ? int'(b[4:0]) + 1 : 1;
    endfunction

    task automatic scramble();
        ALUops   = 4'($urandom);
        UNSIGNED = 1'($urandom);
        OPA      = $urandom;
        OPB      = $urandom;
    endtask

    // Issue one op, follow it cycle by cycle to DONE, and check timing, BUSY, hold and result.
    task automatic run_op(input string tag, input logic [3:0] op, input logic uns,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic        eb;
        int          lat;
        int          k;
        model(op, uns, a, b, er, eb);
        lat = exp_lat(op, b);
        @(negedge CLK);
        chk({tag, "_done_idle"}, {31'h0, DONE}, 32'h0);
        START = 1'b1; ALUops = op; UNSIGNED = uns; OPA = a; OPB = b;
        @(negedge CLK);
        START = 1'b0;
        scramble();
        k = 1;
        while (!DONE && k < lat + 4) begin
            chk({tag, "_busy"}, {31'h0, BUSY}, {31'h0, (serial_shift(op) && k < lat)});
            chk({tag, "_hold"}, RESULT, hold_res);
            @(negedge CLK);
            k++;
        end
        chk({tag, "_done"}, {31'h0, DONE}, 32'h1);
        chk({tag, "_lat"}, k, lat);
        chk({tag, "_busy_done"}, {31'h0, BUSY}, 32'h0);
        chk({tag, "_res"}, RESULT, er);
        chk({tag, "_br"}, {31'h0, BRANCH}, {31'h0, eb});
        hold_res = er;
        hold_br  = eb;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [3:0]  rop;
        int          k;

        // Reset held with a pending ADD request: nothing may complete.
        RST = 1'b1; START = 1'b1; ALUops = 4'd0; UNSIGNED = 1'b0;
        OPA = 32'h1234_5678; OPB = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("rst_done",   {31'h0, DONE},   32'h0);
            chk("rst_busy",   {31'h0, BUSY},   32'h0);
            chk("rst_result", RESULT,          32'h0);
            chk("rst_branch", {31'h0, BRANCH}, 32'h0);
        end
        RST = 1'b0; START = 1'b0;

        run_op("add_wrap", 4'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002);
        run_op("sra31",    4'd4, 1'b0, 32'h8000_0000, 32'd31);
        run_op("sll0",     4'd2, 1'b0, 32'hA5C3_0F96, 32'd0);
        run_op("slt_s",    4'd8, 1'b0, 32'hFFFF_FFFF, 32'd1);
        run_op("slt_u",    4'd8, 1'b1, 32'hFFFF_FFFF, 32'd1);
        run_op("ge_eq",    4'd12, 1'b0, 32'd5, 32'd5);
        run_op("ne_eq",    4'd10, 1'b0, 32'd5, 32'd5);
        run_op("sll1",     4'd2, 1'b0, 32'h8000_0001, 32'd1);
        run_op("undef13",  4'd13, 1'b0, 32'h0000_0007, 32'h0000_0007);

        // START while busy must be ignored.
        if (!FAST) begin
            @(negedge CLK);
            START = 1'b1; ALUops = 4'd3; UNSIGNED = 1'b0; OPA = 32'hF000_0000; OPB = 32'd4;
            @(negedge CLK);
            START = 1'b0;
            chk("busy_k1", {31'h0, BUSY}, 32'h1);
            @(negedge CLK);
            START = 1'b1; ALUops = 4'd0; OPA = 32'h0000_0001; OPB = 32'h0000_0001;
            chk("busy_k2", {31'h0, BUSY}, 32'h1);
            @(negedge CLK);
            START = 1'b0;
            k = 3;
            while (!DONE && k < 10) begin
                @(negedge CLK);
                k++;
            end
            chk("busy_lat", k, 5);
            chk("busy_res", RESULT, 32'h0F00_0000);
            hold_res = 32'h0F00_0000; hold_br = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge CLK);
                chk("busy_no_2nd_done", {31'h0, DONE}, 32'h0);
            end
        end else begin
            run_op("srl4", 4'd3, 1'b0, 32'hF000_0000, 32'd4);
        end

        // Back-to-back: second START issued in the first DONE cycle.
        @(negedge CLK);
        START = 1'b1; ALUops = 4'd15; UNSIGNED = 1'b0; OPA = 32'h0; OPB = 32'h1234_5000;
        @(negedge CLK);
        chk("b2b_done1", {31'h0, DONE}, 32'h1);
        chk("b2b_res1",  RESULT, 32'h1234_5000);
        ALUops = 4'd5; OPA = 32'hFF00_FF00; OPB = 32'h0F0F_0F0F;
        @(negedge CLK);
        START = 1'b0;
        chk("b2b_done2", {31'h0, DONE}, 32'h1);
        chk("b2b_res2",  RESULT, 32'hF00F_F00F);
        hold_res = 32'hF00F_F00F; hold_br = 1'b0;
        @(negedge CLK);
        chk("b2b_done_end", {31'h0, DONE}, 32'h0);

        // Reset in the third shift cycle abandons the op.
        if (!FAST) begin
            START = 1'b1; ALUops = 4'd4; OPA = 32'h8000_0000; OPB = 32'd20;
            @(negedge CLK);
            START = 1'b0;
            @(negedge CLK);
            @(negedge CLK);
            RST = 1'b1;
            @(negedge CLK);
            RST = 1'b0;
            chk("rstmid_busy",   {31'h0, BUSY},   32'h0);
            chk("rstmid_result", RESULT,          32'h0);
            chk("rstmid_branch", {31'h0, BRANCH}, 32'h0);
            hold_res = 32'h0; hold_br = 1'b0;
            for (int i = 0; i < 25; i++) begin
                chk("rstmid_no_done", {31'h0, DONE}, 32'h0);
                @(negedge CLK);
            end
        end

        // Randomised ops against the model.
        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            if ($urandom_range(0, 7) == 0) rb = {27'($urandom), 5'd0};
            run_op("rand", rop, 1'($urandom), ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
